// File: rtl/jtpang_pkg.sv
// Shared definitions for the pang graphics ROM arbiter: FSM states, priority
// encodings and requester identifiers.
package jtpang_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int PRIO_RR  = 0;
    localparam int PRIO_OBJ = 1;
    localparam int PRIO_CHR = 2;

    localparam logic REQ_OBJ = 1'b0;
    localparam logic REQ_CHR = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/jtpang_gfx_arb_if.sv
// Bus bundle joining the obj and chr requesters, the SDRAM slot and the
// timeout flag to the graphics ROM arbiter.
interface jtpang_gfx_arb_if #(
    parameter int AW = 17,
    parameter int DW = 32
);
    logic          obj_cs;
    logic [AW-1:0] obj_addr;
    logic [DW-1:0] obj_data;
    logic          obj_ok;
    logic          chr_cs;
    logic [AW-1:0] chr_addr;
    logic [DW-1:0] chr_data;
    logic          chr_ok;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_ok;
    logic          tout;

    modport slave (
        input  obj_cs, obj_addr, chr_cs, chr_addr, rom_data, rom_ok,
        output obj_data, obj_ok, chr_data, chr_ok, rom_cs, rom_addr, tout
    );

    modport master (
        output obj_cs, obj_addr, chr_cs, chr_addr, rom_data, rom_ok,
        input  obj_data, obj_ok, chr_data, chr_ok, rom_cs, rom_addr, tout
    );
endinterface

// File: rtl/jtpang_rom_slot.sv
// One requester's single-entry hit cache: stores the last fetched word, flags
// misses to the arbiter and drives the registered ok/data back to the client.
module jtpang_rom_slot
    import jtpang_pkg::*;
#(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs_i,
    input  logic [AW-1:0] addr_i,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [DW-1:0] fill_data_i,
    output logic          miss_o,
    output logic          ok_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] data_q,  data_d;
    logic          ok_q,    ok_d;
    logic          hit;

    assign hit    = valid_q && (addr_i == addr_q);
    assign miss_o = cs_i && !hit;
    assign ok_o   = ok_q;
    assign data_o = data_q;

    // ok compares against the entry as it stood before any fill this cycle
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ok_d    = cs_i && hit;
        if (fill_i) begin
            valid_d = 1'b1;
            addr_d  = fill_addr_i;
            data_d  = fill_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: rtl/jtpang_gfx_arb.sv
// Graphics ROM arbiter for pang: shares one SDRAM slot between the object
// drawer and the tile fetcher, with a hit cache per requester.
module jtpang_gfx_arb
    import jtpang_pkg::*;
#(
    parameter int AW      = 17,
    parameter int DW      = 32,
    parameter int PRIO    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    jtpang_gfx_arb_if.slave  bus
);

    localparam logic [CNT_W-1:0] TOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             rom_cs_q, rom_cs_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic obj_miss, chr_miss;
    logic accept, obj_fill, chr_fill;
    logic win;

    // The first REQ cycle (cnt_q==0) may carry a stale rom_ok from the previous slot user
    assign accept   = (state_q == ST_REQ) && (cnt_q != '0) && bus.rom_ok;
    assign obj_fill = accept && (owner_q == REQ_OBJ);
    assign chr_fill = accept && (owner_q == REQ_CHR);

    jtpang_rom_slot #(.AW(AW), .DW(DW)) u_obj_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_i        (bus.obj_cs),
        .addr_i      (bus.obj_addr),
        .fill_i      (obj_fill),
        .fill_addr_i (rom_addr_q),
        .fill_data_i (bus.rom_data),
        .miss_o      (obj_miss),
        .ok_o        (bus.obj_ok),
        .data_o      (bus.obj_data)
    );

    jtpang_rom_slot #(.AW(AW), .DW(DW)) u_chr_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_i        (bus.chr_cs),
        .addr_i      (bus.chr_addr),
        .fill_i      (chr_fill),
        .fill_addr_i (rom_addr_q),
        .fill_data_i (bus.rom_data),
        .miss_o      (chr_miss),
        .ok_o        (bus.chr_ok),
        .data_o      (bus.chr_data)
    );

    assign bus.rom_cs   = rom_cs_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.tout     = tout_q;

    always_comb begin
        win = REQ_OBJ;
        if (obj_miss && chr_miss) begin
            case (PRIO)
                PRIO_OBJ: win = REQ_OBJ;
                PRIO_CHR: win = REQ_CHR;
                default:  win = ~last_q;
            endcase
        end else if (chr_miss) begin
            win = REQ_CHR;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        cnt_d      = cnt_q;
        tout_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (obj_miss || chr_miss) begin
                    owner_d    = win;
                    last_d     = win;
                    rom_addr_d = (win == REQ_CHR) ? bus.chr_addr : bus.obj_addr;
                    rom_cs_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (accept) begin
                    rom_cs_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (cnt_q == TOUT_CNT) begin
                    rom_cs_d = 1'b0;
                    tout_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset leaves last_q on chr so obj wins the first round-robin tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ_OBJ;
            last_q     <= REQ_CHR;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            tout_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            tout_q     <= tout_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jtpang_gfx_arb.sv
// Bench for jtpang_gfx_arb: directed vector table, corner-case sequences and
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_jtpang_gfx_arb;

    localparam int AW   = 17;
    localparam int DW   = 32;
    localparam int TOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_obj_cs = 1'b0, i_chr_cs = 1'b0, i_rom_ok = 1'b0;
    logic [AW-1:0] i_obj_addr = '0, i_chr_addr = '0;
    logic [DW-1:0] i_rom_data = '0;

    jtpang_gfx_arb_if #(.AW(AW), .DW(DW)) bus0 ();
    jtpang_gfx_arb_if #(.AW(AW), .DW(DW)) bus1 ();

    assign bus0.obj_cs = i_obj_cs;  assign bus1.obj_cs = i_obj_cs;
    assign bus0.obj_addr = i_obj_addr;  assign bus1.obj_addr = i_obj_addr;
    assign bus0.chr_cs = i_chr_cs;  assign bus1.chr_cs = i_chr_cs;
    assign bus0.chr_addr = i_chr_addr;  assign bus1.chr_addr = i_chr_addr;
    assign bus0.rom_ok = i_rom_ok;  assign bus1.rom_ok = i_rom_ok;
    assign bus0.rom_data = i_rom_data;  assign bus1.rom_data = i_rom_data;

    jtpang_gfx_arb #(.AW(AW), .DW(DW), .PRIO(0), .TIMEOUT(TOUT)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    jtpang_gfx_arb #(.AW(AW), .DW(DW), .PRIO(1), .TIMEOUT(TOUT)) u_dut_p1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding ROM transaction, tracked by its age in cycles
    bit            m_busy = 0, m_done = 0, m_last = 1;
    int            m_age = 0, m_owner = 0;
    bit            m_val[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_data[2];
    logic          e_rom_cs = 0, e_tout = 0;
    logic [AW-1:0] e_rom_addr = '0;
    logic          e_ok[2];

    task automatic model_step();
        logic          cs[2];
        logic [AW-1:0] a[2];
        bit            hit[2], need[2];
        int            w;
        cs[0] = i_obj_cs;  a[0] = i_obj_addr;
        cs[1] = i_chr_cs;  a[1] = i_chr_addr;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_last = 1; m_age = 0; m_owner = 0;
            e_rom_cs = 0; e_rom_addr = '0; e_tout = 0;
            for (int i = 0; i < 2; i++) begin
                m_val[i] = 0; m_addr[i] = '0; m_data[i] = '0; e_ok[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            hit[i]  = m_val[i] && (a[i] == m_addr[i]);
            e_ok[i] = cs[i] && hit[i];
            need[i] = cs[i] && !hit[i];
        end
        e_tout = 0;
        if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (m_age > 0 && i_rom_ok) begin
                m_val[m_owner]  = 1;
                m_addr[m_owner] = e_rom_addr;
                m_data[m_owner] = i_rom_data;
                m_busy = 0; m_done = 1; e_rom_cs = 0;
            end else if (m_age == TOUT) begin
                m_busy = 0; e_rom_cs = 0; e_tout = 1;
            end else begin
                m_age++;
            end
        end else if (need[0] || need[1]) begin
            if (need[0] && need[1]) w = m_last ? 0 : 1;
            else                    w = need[0] ? 0 : 1;
            m_owner = w; m_last = (w == 1); m_busy = 1; m_age = 0;
            e_rom_cs = 1; e_rom_addr = a[w];
        end
    endtask

    task automatic check_model();
        chk("model rom_cs",   {63'd0, bus0.rom_cs}, {63'd0, e_rom_cs});
        chk("model rom_addr", 64'(bus0.rom_addr), 64'(e_rom_addr));
        chk("model tout",     {63'd0, bus0.tout},   {63'd0, e_tout});
        chk("model obj_ok",   {63'd0, bus0.obj_ok}, {63'd0, e_ok[0]});
        chk("model chr_ok",   {63'd0, bus0.chr_ok}, {63'd0, e_ok[1]});
        chk("model obj_data", 64'(bus0.obj_data), 64'(m_data[0]));
        chk("model chr_data", 64'(bus0.chr_data), 64'(m_data[1]));
    endtask

    // Inputs are set before the call; outputs are judged at the following negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic ocs, input logic [AW-1:0] oa, input logic ccs,
                         input logic [AW-1:0] ca, input logic rok, input logic [DW-1:0] rd);
        i_obj_cs = ocs; i_obj_addr = oa; i_chr_cs = ccs; i_chr_addr = ca;
        i_rom_ok = rok; i_rom_data = rd;
    endtask

    typedef struct {
        logic          rst_n;
        logic          ocs;
        logic [AW-1:0] oaddr;
        logic          rok;
        logic [DW-1:0] rdata;
        logic          e_rcs;
        logic [AW-1:0] e_raddr;
        logic          e_ook;
        logic [DW-1:0] e_odata;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int okp;
        tbl[0]  = '{1'b0, 1'b0, 17'h00, 1'b0, 32'h0,        1'b0, 17'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 17'h10, 1'b0, 32'h0,        1'b1, 17'h10, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 17'h10, 1'b0, 32'h0,        1'b1, 17'h10, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 17'h10, 1'b0, 32'h0,        1'b1, 17'h10, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 17'h10, 1'b1, 32'hDEADBEEF, 1'b0, 17'h10, 1'b0, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 1'b1, 17'h10, 1'b0, 32'h0,        1'b0, 17'h10, 1'b1, 32'hDEADBEEF};
        tbl[6]  = '{1'b1, 1'b0, 17'h10, 1'b0, 32'h0,        1'b0, 17'h10, 1'b0, 32'hDEADBEEF};
        tbl[7]  = '{1'b1, 1'b0, 17'h10, 1'b0, 32'h0,        1'b0, 17'h10, 1'b0, 32'hDEADBEEF};
        tbl[8]  = '{1'b1, 1'b1, 17'h10, 1'b0, 32'h0,        1'b0, 17'h10, 1'b1, 32'hDEADBEEF};
        tbl[9]  = '{1'b1, 1'b1, 17'h20, 1'b0, 32'h0,        1'b1, 17'h20, 1'b0, 32'hDEADBEEF};
        tbl[10] = '{1'b1, 1'b1, 17'h20, 1'b1, 32'h11111111, 1'b1, 17'h20, 1'b0, 32'hDEADBEEF};
        tbl[11] = '{1'b1, 1'b1, 17'h20, 1'b1, 32'h22222222, 1'b0, 17'h20, 1'b0, 32'h22222222};
        tbl[12] = '{1'b1, 1'b1, 17'h20, 1'b0, 32'h0,        1'b0, 17'h20, 1'b1, 32'h22222222};

        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n;
            drive(tbl[i].ocs, tbl[i].oaddr, 1'b0, '0, tbl[i].rok, tbl[i].rdata);
            tick();
            chk($sformatf("vec%0d rom_cs", i),   {63'd0, bus0.rom_cs}, {63'd0, tbl[i].e_rcs});
            chk($sformatf("vec%0d rom_addr", i), 64'(bus0.rom_addr), 64'(tbl[i].e_raddr));
            chk($sformatf("vec%0d obj_ok", i),   {63'd0, bus0.obj_ok}, {63'd0, tbl[i].e_ook});
            chk($sformatf("vec%0d obj_data", i), 64'(bus0.obj_data), 64'(tbl[i].e_odata));
        end

        // Simultaneous misses after obj was served last
        drive(1'b1, 17'h30, 1'b1, 17'h40, 1'b0, '0);
        tick();
        chk("rr first grant chr", 64'(bus0.rom_addr), 64'h40);
        chk("prio1 first grant obj", 64'(bus1.rom_addr), 64'h30);
        tick();
        i_rom_ok = 1'b1; i_rom_data = 32'hC0C00040;
        tick();
        i_rom_ok = 1'b0;
        tick();
        chk("rr chr_ok", {63'd0, bus0.chr_ok}, 64'd1);
        tick();
        chk("rr second grant obj", 64'(bus0.rom_addr), 64'h30);
        chk("rr second rom_cs", {63'd0, bus0.rom_cs}, 64'd1);
        chk("prio1 second grant chr", 64'(bus1.rom_addr), 64'h40);
        tick();
        i_rom_ok = 1'b1; i_rom_data = 32'h0B0B0030;
        tick();
        i_rom_ok = 1'b0;
        tick();
        tick();
        chk("rr obj_data", 64'(bus0.obj_data), 64'h0B0B0030);

        // Timeout with no rom_ok at all
        drive(1'b1, 17'h50, 1'b0, '0, 1'b0, '0);
        tick();
        for (int k = 1; k <= TOUT; k++) begin
            tick();
            chk($sformatf("tmo wait%0d rom_cs", k), {63'd0, bus0.rom_cs}, 64'd1);
            chk($sformatf("tmo wait%0d tout", k), {63'd0, bus0.tout}, 64'd0);
        end
        tick();
        chk("tmo tout pulse", {63'd0, bus0.tout}, 64'd1);
        chk("tmo rom_cs low", {63'd0, bus0.rom_cs}, 64'd0);
        chk("tmo obj_ok low", {63'd0, bus0.obj_ok}, 64'd0);
        tick();
        chk("tmo tout cleared", {63'd0, bus0.tout}, 64'd0);
        chk("tmo rearbitrated", {63'd0, bus0.rom_cs}, 64'd1);
        tick();
        drive(1'b0, 17'h50, 1'b0, '0, 1'b1, 32'h55555555);
        tick();
        i_rom_ok = 1'b0;
        tick();
        tick();

        // chr address change mid-transaction, then reset mid-transaction
        drive(1'b0, 17'h50, 1'b1, 17'h60, 1'b0, '0);
        tick();
        chk("chg grant", 64'(bus0.rom_addr), 64'h60);
        i_chr_addr = 17'h61;
        tick();
        i_rom_ok = 1'b1; i_rom_data = 32'h66666666;
        tick();
        chk("chg no ok at fill", {63'd0, bus0.chr_ok}, 64'd0);
        i_rom_ok = 1'b0;
        tick();
        chk("chg stale ok", {63'd0, bus0.chr_ok}, 64'd0);
        tick();
        chk("chg new grant", 64'(bus0.rom_addr), 64'h61);
        tick();
        rst_n = 1'b0; i_rom_ok = 1'b1;
        tick();
        chk("rst rom_cs", {63'd0, bus0.rom_cs}, 64'd0);
        chk("rst rom_addr", 64'(bus0.rom_addr), 64'd0);
        chk("rst chr_data", 64'(bus0.chr_data), 64'd0);
        chk("rst obj_data", 64'(bus0.obj_data), 64'd0);
        rst_n = 1'b1; i_rom_ok = 1'b0; i_chr_addr = 17'h60;
        tick();
        chk("rst cache invalid", {63'd0, bus0.rom_cs}, 64'd1);
        chk("rst chr_ok", {63'd0, bus0.chr_ok}, 64'd0);

        // Randomized traffic over a small shared address pool
        okp = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: okp = 0;
                    1: okp = 15;
                    default: okp = 50;
                endcase
            end
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) begin
                i_obj_cs = ($urandom_range(0, 3) != 0);
                i_obj_addr = 17'h100 + 17'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                i_chr_cs = ($urandom_range(0, 3) != 0);
                i_chr_addr = 17'h100 + 17'($urandom_range(0, 3));
            end
            i_rom_ok = ($urandom_range(0, 99) < okp);
            i_rom_data = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
